huffman_gen: RTL and testbench

Parametrised Huffman encoder, successor to the fixed six-symbol coder in the image-compression path. It histograms a burst of symbols on `gray_data`, builds a Huffman tree over `NSYM` symbols with a deterministic tie-break, and emits per-symbol code words (`HC`) and length masks (`M`). It adds count saturation, an out-of-range drop counter and back-to-back frame support.

---
 rtl/huffman_pkg.sv | 30 +++
 rtl/huffman_min2.sv | 46 ++++
 rtl/huffman_gen.sv | 163 ++++++++++++++++
 tb/tb_huffman_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and elaboration helpers for the Huffman encoder.
package huffman_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        CNT_OUT,
        MERGE,
        ASSIGN,
        DONE
    } state_t;

    localparam int MIN_NSYM = 2;
    localparam int MAX_NSYM = 8;

    function automatic bit nsym_ok(input int nsym);
        return (nsym >= MIN_NSYM) && (nsym <= MAX_NSYM);
    endfunction

    // Sum of up to 8 saturated counts needs 3 bits of headroom.
    function automatic int weight_width(input int cw);
        return cw + 3;
    endfunction

    // Width of a node index into the 2*NSYM-1 entry node table.
    function automatic int node_idx_width(input int nsym);
        return $clog2(2 * nsym - 1);
    endfunction

endpackage

// File: rtl/huffman_min2.sv
// Combinational finder of the two smallest active weights; lower index wins ties.
module huffman_min2
    import huffman_pkg::*;
#(
    parameter int NN = 11,
    parameter int WW = 11,
    parameter int IW = 4
) (
    input  logic [NN-1:0]    active,
    input  logic [NN*WW-1:0] weights,
    output logic [IW-1:0]    min1,
    output logic [IW-1:0]    min2
);

    logic          have1;
    logic          have2;
    logic [WW-1:0] w1;
    logic [WW-1:0] w2;

    // Ascending scan with strict compares keeps the earlier index on equal weights.
    always_comb begin
        have1 = 1'b0;
        have2 = 1'b0;
        w1    = '0;
        w2    = '0;
        min1  = '0;
        min2  = '0;
        for (int i = 0; i < NN; i++) begin
            if (active[i]) begin
                if (!have1 || (weights[i*WW +: WW] < w1)) begin
                    min2  = min1;
                    w2    = w1;
                    have2 = have1;
                    min1  = IW'(i);
                    w1    = weights[i*WW +: WW];
                    have1 = 1'b1;
                end else if (!have2 || (weights[i*WW +: WW] < w2)) begin
                    min2  = IW'(i);
                    w2    = weights[i*WW +: WW];
                    have2 = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/huffman_gen.sv
// Histograms a symbol burst, builds a Huffman tree one merge per cycle,
// then expands codes top-down one internal node per cycle.
module huffman_gen
    import huffman_pkg::*;
#(
    parameter int NSYM = 6,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gray_valid,
    input  logic [7:0]           gray_data,
    output logic                 CNT_valid,
    output logic [NSYM*CW-1:0]   CNT,
    output logic [7:0]           drop_cnt,
    output logic                 code_valid,
    output logic [NSYM*8-1:0]    HC,
    output logic [NSYM*8-1:0]    M
);

    localparam int WW   = weight_width(CW);
    localparam int NN   = 2 * NSYM - 1;
    localparam int IW   = node_idx_width(NSYM);
    localparam int ROOT = NN - 1;

    typedef logic [IW-1:0] node_idx_t;

    if (!nsym_ok(NSYM)) begin : g_bad_nsym
        $error("huffman_gen: NSYM must lie in 2..8");
    end

    state_t           state;
    state_t           state_next;
    node_idx_t        node_ptr;
    node_idx_t        min1;
    node_idx_t        min2;
    logic [CW-1:0]    cnt_r  [NSYM];
    logic [WW-1:0]    weight [NN];
    node_idx_t        child1 [NN];
    node_idx_t        child0 [NN];
    // Entries 0..NSYM-1 are the leaf codes and drive HC/M directly.
    logic [7:0]       code_r [NN];
    logic [7:0]       mask_r [NN];
    logic [NN-1:0]    active;
    logic [NN*WW-1:0] weight_flat;
    logic [NSYM-1:0]  hit;
    logic             in_range;
    logic             frame_start;
    logic             merge_last;
    logic             assign_last;

    for (genvar s = 0; s < NSYM; s++) begin : g_sym
        assign hit[s]            = (gray_data == 8'(s + 1));
        assign CNT[s*CW +: CW]   = cnt_r[s];
        assign HC[s*8 +: 8]      = code_r[s];
        assign M[s*8 +: 8]       = mask_r[s];
    end

    for (genvar n = 0; n < NN; n++) begin : g_wflat
        assign weight_flat[n*WW +: WW] = weight[n];
    end

    assign in_range    = |hit;
    assign merge_last  = (node_ptr == IW'(ROOT));
    assign assign_last = (node_ptr == IW'(NSYM));

    huffman_min2 #(
        .NN (NN),
        .WW (WW),
        .IW (IW)
    ) u_min2 (
        .active  (active),
        .weights (weight_flat),
        .min1    (min1),
        .min2    (min2)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (gray_valid) begin
                    state_next  = COUNT;
                    frame_start = 1'b1;
                end
            end
            COUNT:   if (!gray_valid) state_next = CNT_OUT;
            CNT_OUT: state_next = MERGE;
            MERGE:   if (merge_last) state_next = ASSIGN;
            ASSIGN:  if (assign_last) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            drop_cnt   <= '0;
            node_ptr   <= '0;
            active     <= '0;
            for (int i = 0; i < NSYM; i++) cnt_r[i] <= '0;
            for (int i = 0; i < NN; i++) begin
                weight[i] <= '0;
                child1[i] <= '0;
                child0[i] <= '0;
                code_r[i] <= '0;
                mask_r[i] <= '0;
            end
        end else begin
            CNT_valid <= (state == COUNT) && !gray_valid;

            if (frame_start) begin
                code_valid <= 1'b0;
                drop_cnt   <= {7'd0, ~in_range};
                for (int i = 0; i < NSYM; i++) cnt_r[i] <= CW'(hit[i]);
                for (int i = 0; i < NN; i++) begin
                    code_r[i] <= '0;
                    mask_r[i] <= '0;
                end
            end else if ((state == COUNT) && gray_valid) begin
                for (int i = 0; i < NSYM; i++) begin
                    if (hit[i] && (cnt_r[i] != '1)) cnt_r[i] <= cnt_r[i] + 1'b1;
                end
                if (!in_range && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            end

            if (state == CNT_OUT) begin
                for (int i = 0; i < NSYM; i++) weight[i] <= WW'(cnt_r[i]);
                for (int i = NSYM; i < NN; i++) weight[i] <= '0;
                active   <= {{(NN - NSYM){1'b0}}, {NSYM{1'b1}}};
                node_ptr <= IW'(NSYM);
            end

            // node_ptr parks on the root after the last merge, where expansion begins.
            if (state == MERGE) begin
                weight[node_ptr] <= weight[min1] + weight[min2];
                child1[node_ptr] <= min1;
                child0[node_ptr] <= min2;
                active[min1]     <= 1'b0;
                active[min2]     <= 1'b0;
                active[node_ptr] <= 1'b1;
                if (!merge_last) node_ptr <= node_ptr + 1'b1;
            end

            if (state == ASSIGN) begin
                code_r[child1[node_ptr]] <= {code_r[node_ptr][6:0], 1'b1};
                mask_r[child1[node_ptr]] <= {mask_r[node_ptr][6:0], 1'b1};
                code_r[child0[node_ptr]] <= {code_r[node_ptr][6:0], 1'b0};
                mask_r[child0[node_ptr]] <= {mask_r[node_ptr][6:0], 1'b1};
                node_ptr <= node_ptr - 1'b1;
                if (assign_last) code_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_gen.sv
// Self-checking bench: a bottom-up Huffman reference model plus directed frames.
module tb_huffman_gen;

    localparam int N6   = 6;
    localparam int SENT = 1000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        gv6;
    logic        gv2;
    logic [7:0]  gd6;
    logic [7:0]  gd2;
    logic        cnt_valid6;
    logic        code_valid6;
    logic [47:0] cnt6;
    logic [47:0] hc6;
    logic [47:0] m6;
    logic [7:0]  drop6;
    logic        cnt_valid2;
    logic        code_valid2;
    logic [15:0] cnt2;
    logic [15:0] hc2;
    logic [15:0] m2;
    logic [7:0]  drop2;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;
    int fs       = 0;
    int t_end    = SENT;
    int t_last   = 0;
    int stim_q[$];

    logic [47:0] exp_cnt_flat;
    logic [47:0] exp_hc_flat;
    logic [47:0] exp_m_flat;
    logic [7:0]  exp_drop;

    huffman_gen #(.NSYM(6), .CW(8)) dut6 (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gv6),
        .gray_data  (gd6),
        .CNT_valid  (cnt_valid6),
        .CNT        (cnt6),
        .drop_cnt   (drop6),
        .code_valid (code_valid6),
        .HC         (hc6),
        .M          (m6)
    );

    huffman_gen #(.NSYM(2), .CW(8)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gv2),
        .gray_data  (gd2),
        .CNT_valid  (cnt_valid2),
        .CNT        (cnt2),
        .drop_cnt   (drop2),
        .code_valid (code_valid2),
        .HC         (hc2),
        .M          (m2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, wanted %h", name, cyc, actual, expected);
        end
    endtask

    // Reference: saturating histogram, then repeatedly pull the two smallest
    // (weight, index) keys; codes are read bottom-up by walking parent links.
    task automatic build_model(input int n);
        int w[16];
        bit act[16];
        int par[16];
        int bitv[16];
        int cnt[8];
        int drop;
        int a;
        int b;
        int best;
        int node;
        int code;
        int len;
        for (int s = 0; s < 8; s++) cnt[s] = 0;
        drop = 0;
        foreach (stim_q[k]) begin
            if (stim_q[k] >= 1 && stim_q[k] <= n) begin
                if (cnt[stim_q[k] - 1] < 255) cnt[stim_q[k] - 1]++;
            end else if (drop < 255) begin
                drop++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            w[i] = 0; act[i] = 1'b0; par[i] = -1; bitv[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            w[i] = cnt[i]; act[i] = 1'b1;
        end
        for (int m = 0; m < n - 1; m++) begin
            a = -1;
            b = -1;
            for (int pick = 0; pick < 2; pick++) begin
                best = -1;
                for (int i = 0; i < n + m; i++)
                    if (act[i] && (best < 0 || (w[i] * 64 + i) < (w[best] * 64 + best))) best = i;
                act[best] = 1'b0;
                if (pick == 0) a = best; else b = best;
            end
            w[n + m] = w[a] + w[b];
            act[n + m] = 1'b1;
            par[a] = n + m; bitv[a] = 1;
            par[b] = n + m; bitv[b] = 0;
        end
        exp_cnt_flat = '0;
        exp_hc_flat  = '0;
        exp_m_flat   = '0;
        for (int s = 0; s < n; s++) begin
            node = s; code = 0; len = 0;
            while (node != 2 * n - 2 && len < 16) begin
                code = code | (bitv[node] << len);
                len++;
                node = par[node];
            end
            exp_cnt_flat[s*8 +: 8] = 8'(cnt[s]);
            exp_hc_flat[s*8 +: 8]  = 8'(code);
            exp_m_flat[s*8 +: 8]   = 8'((1 << len) - 1);
        end
        exp_drop = 8'(drop);
    endtask

    task automatic fill_counts(input int c0, input int c1, input int c2, input int c3, input int c4, input int c5);
        int c[6];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4; c[5] = c5;
        stim_q.delete();
        for (int r = 0; r < 16; r++)
            for (int s = 0; s < 6; s++)
                if (r < c[s]) stim_q.push_back(s + 1);
    endtask

    task automatic applyStimulus(input int sel);
        foreach (stim_q[k]) begin
            @(posedge clk); #1;
            if (sel == 6) begin
                if (k == 0) begin
                    fs = cyc; t_end = SENT; mode = 2;
                end
                gv6 = 1'b1; gd6 = 8'(stim_q[k]);
            end else begin
                gv2 = 1'b1; gd2 = 8'(stim_q[k]);
            end
        end
        @(posedge clk); #1;
        gv6 = 1'b0; gv2 = 1'b0; gd6 = '0; gd2 = '0;
        t_last = cyc;
        if (sel == 6) begin
            build_model(6);
            t_end = cyc;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (mode == 1) begin
            checkOutput("idle_cnt_valid",  64'(cnt_valid6), 64'd0);
            checkOutput("idle_cnt",        64'(cnt6), 64'd0);
            checkOutput("idle_drop",       64'(drop6), 64'd0);
            checkOutput("idle_code_valid", 64'(code_valid6), 64'd0);
            checkOutput("idle_hc",         64'(hc6), 64'd0);
            checkOutput("idle_m",          64'(m6), 64'd0);
        end else if (mode == 2 && cyc > fs) begin
            checkOutput("cnt_valid_timing",  64'(cnt_valid6), 64'(cyc == t_end + 1));
            checkOutput("code_valid_timing", 64'(code_valid6), 64'(cyc >= t_end + 2 * N6));
            if (cyc <= t_end + N6) begin
                checkOutput("hc_cleared", 64'(hc6), 64'd0);
                checkOutput("m_cleared",  64'(m6), 64'd0);
            end
            if (cyc >= t_end + 1) begin
                checkOutput("cnt_model",  64'(cnt6), 64'(exp_cnt_flat));
                checkOutput("drop_model", 64'(drop6), 64'(exp_drop));
            end
            if (cyc >= t_end + 2 * N6) begin
                checkOutput("hc_model", 64'(hc6), 64'(exp_hc_flat));
                checkOutput("m_model",  64'(m6), 64'(exp_m_flat));
            end
        end
    end

    initial begin
        reset = 1'b1;
        gv6 = 1'b0; gv2 = 1'b0; gd6 = '0; gd2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mode  = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_code_valid2", 64'(code_valid2), 64'd0);
        checkOutput("rst_cnt2",        64'(cnt2), 64'd0);

        // Two-symbol equal-count tie on the NSYM=2 instance.
        stim_q.delete();
        for (int k = 0; k < 8; k++) stim_q.push_back((k % 2) + 1);
        applyStimulus(2);
        wait_until(t_last + 1);
        checkOutput("n2_cnt_valid", 64'(cnt_valid2), 64'd1);
        checkOutput("n2_cnt",       64'(cnt2), 64'h0404);
        checkOutput("n2_drop",      64'(drop2), 64'd0);
        wait_until(t_last + 2);
        checkOutput("n2_cnt_valid_pulse", 64'(cnt_valid2), 64'd0);
        wait_until(t_last + 3);
        checkOutput("n2_code_valid_early", 64'(code_valid2), 64'd0);
        wait_until(t_last + 4);
        checkOutput("n2_code_valid", 64'(code_valid2), 64'd1);
        checkOutput("n2_hc",         64'(hc2), 64'h0001);
        checkOutput("n2_m",          64'(m2), 64'h0101);

        // Basic tree with hand-derived codes.
        fill_counts(5, 1, 2, 3, 4, 6);
        applyStimulus(6);
        checkOutput("model_pin_cnt", 64'(exp_cnt_flat), 64'h0604_0302_0105);
        checkOutput("model_pin_hc",  64'(exp_hc_flat), 64'h0103_0100_0102);
        checkOutput("model_pin_m",   64'(exp_m_flat), 64'h0303_070F_0F03);
        wait_until(t_end + 1);
        checkOutput("basic_cnt_valid", 64'(cnt_valid6), 64'd1);
        checkOutput("basic_cnt",       64'(cnt6), 64'h0604_0302_0105);
        wait_until(t_end + 11);
        checkOutput("basic_code_valid_early", 64'(code_valid6), 64'd0);
        wait_until(t_end + 12);
        checkOutput("basic_code_valid", 64'(code_valid6), 64'd1);
        checkOutput("basic_hc",         64'(hc6), 64'h0103_0100_0102);
        checkOutput("basic_m",          64'(m6), 64'h0303_070F_0F03);
        wait_until(t_end + 14);

        // Back-to-back frame: out-of-range values and bin saturation.
        stim_q.delete();
        stim_q.push_back(0);
        stim_q.push_back(7);
        stim_q.push_back(255);
        for (int k = 0; k < 300; k++) stim_q.push_back(2);
        applyStimulus(6);
        wait_until(t_end + 12);
        checkOutput("sat_drop",       64'(drop6), 64'd3);
        checkOutput("sat_bin2",       64'(cnt6[15:8]), 64'd255);
        checkOutput("sat_bin6",       64'(cnt6[47:40]), 64'd0);
        checkOutput("sat_code_valid", 64'(code_valid6), 64'd1);
        wait_until(t_end + 13);

        // gray_valid pulses during ASSIGN must be ignored.
        fill_counts(2, 0, 7, 1, 2, 1);
        applyStimulus(6);
        wait_until(t_end + N6 + 2);
        gv6 = 1'b1; gd6 = 8'd3;
        @(posedge clk); #1;
        gd6 = 8'd4;
        @(posedge clk); #1;
        gv6 = 1'b0; gd6 = '0;
        wait_until(t_end + 11);
        checkOutput("ign_code_valid_early", 64'(code_valid6), 64'd0);
        wait_until(t_end + 12);
        checkOutput("ign_code_valid", 64'(code_valid6), 64'd1);
        checkOutput("ign_bin3",       64'(cnt6[23:16]), 64'd7);
        wait_until(t_end + 13);

        // Reset in the middle of MERGE aborts the frame.
        fill_counts(3, 1, 4, 1, 5, 9);
        applyStimulus(6);
        wait_until(t_end + 3);
        reset = 1'b1;
        mode  = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        mode  = 1;
        checkOutput("rstmid_code_valid", 64'(code_valid6), 64'd0);
        checkOutput("rstmid_cnt",        64'(cnt6), 64'd0);
        repeat (20) @(posedge clk);
        #1;

        // Fresh frame from IDLE: all-equal weights.
        fill_counts(1, 1, 1, 1, 1, 1);
        applyStimulus(6);
        wait_until(t_end + 12);
        checkOutput("eq_code_valid", 64'(code_valid6), 64'd1);
        checkOutput("eq_hc",         64'(hc6), 64'h0203_0001_0203);
        checkOutput("eq_m",          64'(m6), 64'h0303_0707_0707);
        wait_until(t_end + 14);
        mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
